// File: rtl/mux_n_1_pipe_pkg.sv
// Shared sizing helpers for the pipelined N:1 select tree.
// Level k of the tree carries a packed vector {select[sel_width-1:k], words}.
package mux_n_1_pipe_pkg;

  function automatic int unsigned num_inputs(int unsigned sel_width);
    return 1 << sel_width;
  endfunction

  // Partial words present at tree level k (level 0 is the raw input bus).
  function automatic int unsigned level_words(int unsigned sel_width, int unsigned k);
    return num_inputs(sel_width) >> k;
  endfunction

  function automatic int unsigned level_width(int unsigned bus_size, int unsigned sel_width,
                                              int unsigned k);
    return level_words(sel_width, k) * bus_size + (sel_width - k);
  endfunction

  function automatic int unsigned level_offset(int unsigned bus_size, int unsigned sel_width,
                                               int unsigned k);
    int unsigned ofs;
    ofs = 0;
    for (int unsigned i = 0; i < k; i++) ofs += level_width(bus_size, sel_width, i);
    return ofs;
  endfunction

endpackage

// File: rtl/mux_n_1_pipe_if.sv
// Valid/ready bus of the pipelined N:1 mux: input words + select in, selected word out.
interface mux_n_1_pipe_if
  import mux_n_1_pipe_pkg::*;
#(
  parameter int unsigned bus_size  = 32,
  parameter int unsigned sel_width = 2
);
  logic [num_inputs(sel_width)*bus_size-1:0] in_bus;
  logic [sel_width-1:0]                      select;
  logic                                      in_valid;
  logic                                      in_ready;
  logic [bus_size-1:0]                       out;
  logic                                      out_valid;
  logic                                      out_ready;

  modport master (
    output in_bus, select, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_bus, select, in_valid, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/mux_2_1.sv
// Two-input word select: in1 when sel is high, in0 otherwise.
module mux_2_1 #(
  parameter int unsigned bus_size = 32
) (
  input  logic [bus_size-1:0] in0,
  input  logic [bus_size-1:0] in1,
  input  logic                sel,
  output logic [bus_size-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/mux_n_1_pipe_stage.sv
// One registered tree level: halves the word count using the lowest carried select bit.
module mux_tree_stage #(
  parameter int unsigned bus_size  = 32,
  parameter int unsigned in_words  = 2,
  parameter int unsigned sel_carry = 0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [in_words*bus_size+sel_carry:0]        in_pack_i,
  input  logic                                        in_valid_i,
  input  logic                                        en_next_i,
  output logic                                        en_o,
  output logic [(in_words/2)*bus_size+sel_carry-1:0]  out_pack_o,
  output logic                                        valid_o
);
  localparam int unsigned OUT_WORDS = in_words / 2;
  localparam int unsigned IN_DW     = in_words * bus_size;
  localparam int unsigned OUT_W     = OUT_WORDS * bus_size + sel_carry;

  logic [IN_DW-1:0] words;
  logic             sel_bit;
  logic [OUT_W-1:0] pack_d, pack_q;
  logic             valid_q;

  assign words   = in_pack_i[IN_DW-1:0];
  assign sel_bit = in_pack_i[IN_DW];

  for (genvar j = 0; j < OUT_WORDS; j++) begin : g_mux
    mux_2_1 #(.bus_size(bus_size)) u_mux (
      .in0 (words[(2*j)*bus_size +: bus_size]),
      .in1 (words[(2*j+1)*bus_size +: bus_size]),
      .sel (sel_bit),
      .out (pack_d[j*bus_size +: bus_size])
    );
  end

  // Select bits not consumed here ride along above the partial words.
  if (sel_carry > 0) begin : g_carry
    assign pack_d[OUT_W-1 -: sel_carry] = in_pack_i[IN_DW+sel_carry -: sel_carry];
  end

  assign en_o = !valid_q || en_next_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pack_q  <= '0;
    end else if (en_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) pack_q <= pack_d;
    end
  end

  assign out_pack_o = pack_q;
  assign valid_o    = valid_q;
endmodule

// File: rtl/mux_n_1_pipe.sv
// Pipelined N:1 mux: chains sel_width tree stages, one register per level, valid/ready flow.
module mux_n_1_pipe
  import mux_n_1_pipe_pkg::*;
#(
  parameter int unsigned bus_size  = 32,
  parameter int unsigned sel_width = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_n_1_pipe_if.slave   bus
);
  localparam int unsigned TOT_W = level_offset(bus_size, sel_width, sel_width + 1);

  // All tree levels packed back to back; level k starts at level_offset(k).
  logic [TOT_W-1:0]   lvl;
  logic [sel_width:0] vld;
  logic [sel_width:0] en;

  assign lvl[level_width(bus_size, sel_width, 0)-1:0] = {bus.select, bus.in_bus};
  assign vld[0]         = bus.in_valid;
  assign en[sel_width]  = bus.out_ready;

  for (genvar k = 0; k < sel_width; k++) begin : g_lvl
    localparam int unsigned OFS_IN  = level_offset(bus_size, sel_width, k);
    localparam int unsigned OFS_OUT = level_offset(bus_size, sel_width, k + 1);
    localparam int unsigned IN_W    = level_width(bus_size, sel_width, k);
    localparam int unsigned OUT_W   = level_width(bus_size, sel_width, k + 1);

    mux_tree_stage #(
      .bus_size  (bus_size),
      .in_words  (level_words(sel_width, k)),
      .sel_carry (sel_width - k - 1)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_pack_i  (lvl[OFS_IN +: IN_W]),
      .in_valid_i (vld[k]),
      .en_next_i  (en[k+1]),
      .en_o       (en[k]),
      .out_pack_o (lvl[OFS_OUT +: OUT_W]),
      .valid_o    (vld[k+1])
    );
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = vld[sel_width];
  assign bus.out       = lvl[TOT_W-1 -: bus_size];
endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Bench for mux_n_1_pipe: directed + random traffic on sel_width=2, random sweeps for 1/3/5.
module tb_mux_n_1_pipe;
  localparam int unsigned BW   = 32;
  localparam int unsigned WMAX = 32 * BW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   sw_done [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: word number sel of the packed bus, by plain shifting.
  function automatic logic [BW-1:0] ref_pick(input logic [WMAX-1:0] wide, input int unsigned sel);
    return BW'(wide >> (sel * BW));
  endfunction

  // ---------------- sel_width = 2 instance ----------------
  mux_n_1_pipe_if #(.bus_size(BW), .sel_width(2)) b2 ();
  mux_n_1_pipe #(.bus_size(BW), .sel_width(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  logic [BW-1:0] q2 [$];
  int            qc2 [$];
  bit            exact2 = 1'b1;
  logic          hold2 = 1'b0;
  logic [BW-1:0] held2 = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q2.delete();
      qc2.delete();
      hold2 <= 1'b0;
    end else begin
      if (hold2) begin
        check("w2_stall_valid", b2.out_valid, 1);
        check("w2_stall_data", b2.out, held2);
      end
      if (q2.size() == 0) check("w2_idle_valid", b2.out_valid, 0);
      else if (b2.out_valid && b2.out_ready) begin
        check("w2_data", b2.out, q2.pop_front());
        if (exact2) check("w2_latency", cyc - qc2.pop_front(), 2);
        else void'(qc2.pop_front());
      end
      hold2 <= b2.out_valid && !b2.out_ready;
      held2 <= b2.out;
      if (b2.in_valid && b2.in_ready) begin
        q2.push_back(ref_pick(WMAX'(b2.in_bus), 32'(b2.select)));
        qc2.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic rdy);
    @(posedge clk);
    #1;
    b2.in_valid  = v;
    b2.select    = s;
    b2.out_ready = rdy;
  endtask

  task automatic rand_bus2();
    for (int j = 0; j < 4; j++) b2.in_bus[j*BW +: BW] = $urandom;
  endtask

  // ---------------- sweep instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int unsigned SW = (gi == 0) ? 1 : (gi == 1) ? 3 : 5;
    localparam int unsigned NW = 1 << SW;

    mux_n_1_pipe_if #(.bus_size(BW), .sel_width(SW)) bs ();
    mux_n_1_pipe #(.bus_size(BW), .sel_width(SW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bs.slave)
    );

    logic [BW-1:0] q [$];
    int            qc [$];

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        qc.delete();
      end else begin
        if (q.size() == 0) check($sformatf("sw%0d_idle_valid", SW), bs.out_valid, 0);
        else if (bs.out_valid) begin
          check($sformatf("sw%0d_data", SW), bs.out, q.pop_front());
          check($sformatf("sw%0d_latency", SW), cyc - qc.pop_front(), SW);
        end
        if (bs.in_valid && bs.in_ready) begin
          q.push_back(ref_pick(WMAX'(bs.in_bus), 32'(bs.select)));
          qc.push_back(cyc);
        end
      end
    end

    initial begin
      bs.in_valid  = 1'b0;
      bs.select    = '0;
      bs.in_bus    = '0;
      bs.out_ready = 1'b1;
      wait (rst_n);
      for (int c = 0; c < 250; c++) begin
        @(posedge clk);
        #1;
        for (int j = 0; j < int'(NW); j++) bs.in_bus[j*BW +: BW] = $urandom;
        bs.select   = SW'($urandom_range(NW - 1));
        bs.in_valid = ($urandom % 4) != 0;
      end
      @(posedge clk);
      #1 bs.in_valid = 1'b0;
      repeat (SW + 3) @(posedge clk);
      @(negedge clk);
      check($sformatf("sw%0d_drain", SW), q.size(), 0);
      sw_done[gi] = 1'b1;
    end
  end

  // ---------------- directed + random sequence on sel_width = 2 ----------------
  initial begin
    logic [BW-1:0] route_exp [4];
    logic [1:0]    sel_t [4];
    logic [BW-1:0] bw [4];
    bit            all_done;

    route_exp[0] = 32'hAAAA0000;
    route_exp[1] = 32'hBBBB0001;
    route_exp[2] = 32'hCCCC0002;
    route_exp[3] = 32'hDDDD0003;
    b2.in_valid  = 1'b0;
    b2.select    = '0;
    b2.out_ready = 1'b1;
    b2.in_bus    = '0;

    // Reset state
    #2;
    check("rst_out", b2.out, 0);
    check("rst_out_valid", b2.out_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", b2.in_ready, 1);

    // Routing, back to back
    b2.in_bus = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int t = 0; t < 7; t++) begin
      drive(t < 4, 2'(t), 1'b1);
      @(negedge clk);
      if (t >= 2 && t <= 5) begin
        check("route_valid", b2.out_valid, 1);
        check("route_data", b2.out, route_exp[t-2]);
      end else check("route_gap_valid", b2.out_valid, 0);
    end

    // Back-pressure: 3 inputs against a stalled output
    exact2 = 1'b0;
    rand_bus2();
    for (int j = 0; j < 4; j++) bw[j] = b2.in_bus[j*BW +: BW];
    sel_t[0] = 2'd1; sel_t[1] = 2'd2; sel_t[2] = 2'd3; sel_t[3] = 2'd3;
    for (int t = 0; t < 8; t++) begin
      drive(t < 5, sel_t[(t < 2) ? t : 2], t >= 4);
      @(negedge clk);
      case (t)
        0, 1: check("bp_in_ready_open", b2.in_ready, 1);
        2, 3: begin
          check("bp_in_ready_full", b2.in_ready, 0);
          check("bp_hold_data", b2.out, bw[1]);
        end
        4: begin
          check("bp_in_ready_release", b2.in_ready, 1);
          check("bp_out_first", b2.out, bw[1]);
        end
        5: check("bp_out_second", b2.out, bw[2]);
        6: check("bp_out_third", b2.out, bw[3]);
        default: check("bp_empty_after", b2.out_valid, 0);
      endcase
    end

    // Bubbles: in_valid 1,0,1
    exact2 = 1'b1;
    rand_bus2();
    for (int j = 0; j < 4; j++) bw[j] = b2.in_bus[j*BW +: BW];
    sel_t[0] = 2'($urandom_range(3));
    sel_t[1] = 2'($urandom_range(3));
    for (int t = 0; t < 7; t++) begin
      drive(t == 0 || t == 2, (t == 2) ? sel_t[1] : sel_t[0], 1'b1);
      @(negedge clk);
      check("bub_valid", b2.out_valid, (t == 2 || t == 4) ? 1 : 0);
      if (t == 2 || t == 3) check("bub_data_first", b2.out, bw[sel_t[0]]);
      if (t == 4) check("bub_data_second", b2.out, bw[sel_t[1]]);
    end

    // Reset with two words in flight
    rand_bus2();
    for (int j = 0; j < 4; j++) bw[j] = b2.in_bus[j*BW +: BW];
    drive(1'b1, 2'd2, 1'b1);
    drive(1'b1, 2'd3, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rstm_out_valid", b2.out_valid, 0);
    check("rstm_out", b2.out, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rstm_in_ready", b2.in_ready, 1);
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 2'd0, 1'b1);
      @(negedge clk);
      check("rstm_no_ghost", b2.out_valid, 0);
    end
    for (int t = 0; t < 4; t++) begin
      drive(t == 0, 2'd1, 1'b1);
      @(negedge clk);
      check("rstm_new_valid", b2.out_valid, (t == 2) ? 1 : 0);
      if (t == 2) check("rstm_new_data", b2.out, bw[1]);
    end

    // Random traffic with random back-pressure
    exact2 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rand_bus2();
      b2.select    = 2'($urandom_range(3));
      b2.in_valid  = ($urandom % 3) != 0;
      b2.out_ready = ($urandom % 3) != 0;
    end
    for (int c = 0; c < 10; c++) drive(1'b0, 2'd0, 1'b1);
    @(negedge clk);
    check("w2_drain", q2.size(), 0);

    all_done = 1'b0;
    for (int i = 0; i < 2000 && !all_done; i++) begin
      @(posedge clk);
      all_done = sw_done[0] && sw_done[1] && sw_done[2];
    end
    check("sweep_done", all_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_n_1_pipe.md
Name: mux_n_1_pipe

Overview:
- Parametrised, pipelined N-to-1 multiplexer: the next generation of the datapath 2:1/4:1 select muxes.
- Built as a binary tree of 2:1 select levels, with one register stage per tree level and valid/ready flow control.
- Used where wide operand, forwarding or writeback selection must be retimed across cycles without breaking pipeline stall semantics.
- Throughput is one word per cycle; latency is sel_width cycles.

Parameters:
- bus_size, 32, width of each data word.
- sel_width, 2, select width; number of inputs N = 2**sel_width; legal range 1..5.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bus  input  N*bus_size  packed input words; word j occupies bits [j*bus_size +: bus_size].
- select  input  sel_width  index of the word to route; select = j routes word j.
- in_valid  input  1  in_bus and select carry a transfer.
- in_ready  output  1  block accepts a transfer this cycle.
- out  output  bus_size  selected word.
- out_valid  output  1  out carries a result.
- out_ready  input  1  downstream accepts out this cycle.

Behaviour:
- Interface timing is fixed: one clock, clk; asynchronous active-low reset, rst_n. Reset is asserted asynchronously; release is sampled on clk.
- Reset values:
  - all stage valid bits 0;
  - all stage data and select registers 0;
  - out = 0, out_valid = 0.
  - in_ready = 1 while rst_n is high after reset, because every stage is empty.
- Pipeline structure:
  - Stages k = 0..sel_width-1.
  - Stage k holds N/2**(k+1) partial words, the unused select bits [sel_width-1:k+1], and a valid bit v[k].
  - Stage 0 reduces in_bus pairwise using select[0]: the even word is chosen when the bit is 0, the odd word when it is 1.
  - Stage k > 0 reduces the stage k-1 partial words pairwise using the carried select bit k.
  - The last stage holds exactly one word, which drives out; v[last] drives out_valid.
- Enable rules:
  - The last stage loads when en[last] = !v[last] || out_ready.
  - Stage k loads when en[k] = !v[k] || en[k+1].
  - in_ready = en[0], combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Stage update:
  - On en[k]: v[k] <= valid of the feeding stage (in_valid for stage 0), and the data/select registers load.
  - When en[k] is low, stage k holds.
  - Data registers load only when the incoming valid is 1; bubbles do not disturb stored data.
- Transfer rules:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - Each accepted input produces exactly one output, in order, sel_width cycles later if never stalled.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Stall: while out_valid && !out_ready, out and out_valid stay stable. Up to sel_width transfers are buffered before in_ready drops.
- Simultaneous events: a full pipe with out_ready = 1 and in_valid = 1 shifts every stage in the same cycle, sustaining full throughput.
- Reset mid-operation: all in-flight words are discarded immediately; no output is produced for them after release.
- Select semantics are identical to the existing 4:1 mux for sel_width = 2: 0→word0, 1→word1, 2→word2, 3→word3.

Decomposition:
- Shared header/package: localparam N = 1 << sel_width, plus a function for the partial-word count per level.
- Sub-module mux_tree_stage, one tree level, with these parameters:
  - bus_size;
  - in_words;
  - carried select width.
- mux_tree_stage contents:
  - in_words/2 instances of the existing mux_2_1;
  - the valid/data/select registers;
  - the en logic.
- The top level only chains the stages with a generate loop and ties the end conditions.

Test Plan:
- All tests use bus_size = 32, sel_width = 2.
- Reset check: assert rst_n = 0 mid-cycle → out = 0 and out_valid = 0 asynchronously; after release, in_ready = 1.
- Routing: in_bus words {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, select = 0..3 back-to-back, out_ready = 1.
  - Required: out = 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 on cycles 2, 3, 4, 5 after the first accept.
  - Required: out_valid continuous across those four outputs.
- Back-pressure: hold out_ready = 0 while issuing 3 inputs.
  - Required: first 2 accepted, in_ready = 0 on the 3rd, out stable.
  - Release out_ready → all 3 appear in order with no loss or duplication.
- Bubbles: in_valid pattern 1,0,1 with out_ready = 1 → out_valid pattern 1,0,1 delayed by 2 cycles; out data on the bubble cycle is unchanged.
- Reset mid-flight: 2 words in flight, pulse rst_n low for 1 cycle → no out_valid afterwards until new input; the next input gives its correct result at latency 2.
- Parameter sweep: repeat routing for sel_width = 1, 3, 5 with random data versus a reference model → latency equals sel_width and every output matches in_bus[select].
